// File: rtl/knn_sched_pkg.sv
// knn_pkg: definitions shared by the KNN scheduler and the knn core.
//   - default point and label widths, matching the core's defaults
//   - coordinate split of a packed point (x in the upper half, y in the lower half)
//   - scheduler state encoding and the enum built on it
//   - small helpers to pull x/y out of a packed point
package knn_pkg;

  localparam int KNN_DATA_W  = 32;
  localparam int KNN_LABEL_W = 8;

  localparam int X_MSB = 31;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 15;
  localparam int Y_LSB = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    FETCH = ST_FETCH,
    DRAIN = ST_DRAIN,
    FIN   = ST_FIN
  } sched_state_t;

  function automatic logic [X_MSB-X_LSB:0] point_x(input logic [KNN_DATA_W-1:0] p);
    return p[X_MSB:X_LSB];
  endfunction

  function automatic logic [Y_MSB-Y_LSB:0] point_y(input logic [KNN_DATA_W-1:0] p);
    return p[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/knn_sched_if.sv
// knn_sched_if: bus between the KNN scheduler, the training memory and the knn core.
//   Memory side : mem_en, mem_addr (scheduler out), mem_data, mem_label (memory out,
//                 valid the cycle after mem_en)
//   Core side   : core_A, core_B, core_label, core_valid, core_start (scheduler out)
// Modports: master = scheduler, slave = memory/core environment.
interface knn_sched_if #(
  parameter int DATA_W = 32,
  parameter int LABEL  = 8,
  parameter int ADDR_W = 10
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [LABEL-1:0]  mem_label;
  logic [DATA_W-1:0] core_A;
  logic [DATA_W-1:0] core_B;
  logic [LABEL-1:0]  core_label;
  logic              core_valid;
  logic              core_start;

  modport master (
    output mem_en, mem_addr, core_A, core_B, core_label, core_valid, core_start,
    input  mem_data, mem_label
  );

  modport slave (
    input  mem_en, mem_addr, core_A, core_B, core_label, core_valid, core_start,
    output mem_data, mem_label
  );

endinterface

// File: rtl/knn_addr_gen.sv
// knn_addr_gen: training memory address counter.
//   clk, rst (async, active-low)
//   clear   : force the counter back to 0
//   advance : scheduler is in its fetch phase
//   hold    : stall request; no read is issued and the address holds
//   n_train : number of points in this run (ADDR_W+1 bits so 2^ADDR_W is legal)
//   issue   : a read is issued this cycle (drives mem_en)
//   addr    : read address
//   last    : current address is the final point (n_train-1)
module knn_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic              hold,
  input  logic [ADDR_W:0]   n_train,
  output logic              issue,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  // One bit wider than the address so a full-depth run never wraps
  // before the terminal compare sees n_train-1.
  logic [ADDR_W:0] cnt;

  assign issue = advance & ~hold;
  assign last  = (cnt == n_train - ONE);
  assign addr  = cnt[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (issue && !last) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/knn_sched.sv
// knn_sched: sequencer for the KNN distance/list datapath.
// On run it latches the test point, pulses core_start to clear the neighbour
// list, streams n_train training rows from a 1-cycle-latency memory into the
// core (one core_valid per row), waits LIST_LAT cycles for the list to settle
// and pulses done.
// Ports:
//   clk, rst (async, active-low)
//   run, test_point, n_train : request and its arguments, sampled on accept
//   pause                    : fetch stall (only with KNN_SCHED_PAUSE_EN)
//   busy, done               : status; done is a 1-cycle pulse
//   bus                      : knn_sched_if master (memory + core signals)
// Optional feature macro: KNN_SCHED_PAUSE_EN adds the pause input.
module knn_sched
  import knn_pkg::*;
#(
  parameter int DATA_W   = KNN_DATA_W,
  parameter int LABEL    = KNN_LABEL_W,
  parameter int ADDR_W   = 10,
  parameter int LIST_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] test_point,
  input  logic [ADDR_W:0]   n_train,
`ifdef KNN_SCHED_PAUSE_EN
  input  logic              pause,
`endif
  output logic              busy,
  output logic              done,
  knn_sched_if.master       bus
);

  localparam int DRAIN_W = $clog2(LIST_LAT + 2);
  // The +1 covers the cycle in which the final read's core_valid is still out.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(LIST_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  sched_state_t       state;
  logic [ADDR_W:0]    n_reg;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DATA_W-1:0]  core_a_q;
  logic               core_start_q;
  logic               en_d;
  logic               stall;
  logic               issue;
  logic               last;
  logic [ADDR_W-1:0]  addr;

`ifdef KNN_SCHED_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  knn_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .advance (state == FETCH),
    .hold    (stall),
    .n_train (n_reg),
    .issue   (issue),
    .addr    (addr),
    .last    (last)
  );

  // Memory data arrives one cycle after the read, so core_valid is the
  // delayed read enable; B/label are gated to stay 0 outside valid cycles.
  assign bus.mem_en     = issue;
  assign bus.mem_addr   = addr;
  assign bus.core_A     = core_a_q;
  assign bus.core_start = core_start_q;
  assign bus.core_valid = en_d;
  assign bus.core_B     = en_d ? bus.mem_data  : '0;
  assign bus.core_label = en_d ? bus.mem_label : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      n_reg        <= '0;
      drain_cnt    <= '0;
      en_d         <= 1'b0;
    end else begin
      en_d         <= issue;
      core_start_q <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            core_a_q     <= test_point;
            n_reg        <= n_train;
            busy         <= 1'b1;
            core_start_q <= 1'b1;
            state        <= CLEAR;
          end
        end
        CLEAR: begin
          if (n_reg == '0) begin
            drain_cnt <= DRAIN_LOAD;
            state     <= DRAIN;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (issue && last) begin
            drain_cnt <= DRAIN_LOAD;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_sched.sv
// tb_knn_sched: self-checking bench for knn_sched.
// A negedge monitor logs every core_start, core_valid (with B/label), issued
// read address and done into queues, tagged with a cycle number. Each test
// task launches runs with random data and compares those logs against what
// the run should produce: rows 0..n-1 in order, first valid 2 cycles after
// the accept, done n + LIST_LAT + 3 cycles after it (plus paused cycles).
// Macro KNN_SCHED_PAUSE_EN enables the pause scenario.
module tb_knn_sched;

  localparam int DATA_W   = 32;
  localparam int LABEL    = 8;
  localparam int ADDR_W   = 10;
  localparam int LIST_LAT = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic [DATA_W-1:0] test_point = '0;
  logic [ADDR_W:0]   n_train = '0;
  logic              busy;
  logic              done;
`ifdef KNN_SCHED_PAUSE_EN
  logic              pause = 1'b0;
`endif

  knn_sched_if #(.DATA_W(DATA_W), .LABEL(LABEL), .ADDR_W(ADDR_W)) bus ();

  knn_sched #(.DATA_W(DATA_W), .LABEL(LABEL), .ADDR_W(ADDR_W), .LIST_LAT(LIST_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .test_point (test_point),
    .n_train    (n_train),
`ifdef KNN_SCHED_PAUSE_EN
    .pause      (pause),
`endif
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [LABEL-1:0]  mem_l [DEPTH];

  int                start_cyc [$];
  int                done_cyc  [$];
  int                v_cyc     [$];
  logic [DATA_W-1:0] v_b       [$];
  logic [LABEL-1:0]  v_l       [$];
  int                a_q       [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous training memory, one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_data  <= mem_d[bus.mem_addr];
      bus.mem_label <= mem_l[bus.mem_addr];
    end
  end

  always @(negedge clk) begin
    if (bus.core_start) start_cyc.push_back(cyc);
    if (bus.core_valid) begin
      v_cyc.push_back(cyc);
      v_b.push_back(bus.core_B);
      v_l.push_back(bus.core_label);
    end
    if (bus.mem_en) a_q.push_back(int'(bus.mem_addr));
    if (done) done_cyc.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_logs();
    start_cyc.delete();
    done_cyc.delete();
    v_cyc.delete();
    v_b.delete();
    v_l.delete();
    a_q.delete();
  endtask

  // Drive a 1-cycle run; returns the cycle number of the accept (CLEAR cycle)
  task automatic launch(input logic [DATA_W-1:0] tp, input int n, output int r);
    @(negedge clk);
    run = 1'b1;
    test_point = tp;
    n_train = (ADDR_W+1)'(n);
    @(negedge clk);
    run = 1'b0;
    r = cyc;
  endtask

  task automatic test_reset();
    int r;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bus.mem_en, bus.core_valid, bus.core_start} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL por_ctrl: got %b expected 00000",
               {busy, done, bus.mem_en, bus.core_valid, bus.core_start});
    end
    n_checks++;
    if ({bus.mem_addr, bus.core_A, bus.core_B, bus.core_label} !== '0) begin
      n_fail++;
      $display("[TB] FAIL por_data: got addr=%0h A=%0h B=%0h L=%0h expected all 0",
               bus.mem_addr, bus.core_A, bus.core_B, bus.core_label);
    end
    rst = 1'b1;
    @(negedge clk);

    clear_logs();
    launch($urandom, 8, r);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.mem_en !== 1'b1 || bus.core_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_prefetch: got en=%b valid=%b expected 1 1",
               bus.mem_en, bus.core_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.mem_en, bus.core_valid, bus.core_start} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL async_ctrl: got %b expected 00000",
               {busy, done, bus.mem_en, bus.core_valid, bus.core_start});
    end
    n_checks++;
    if ({bus.mem_addr, bus.core_A, bus.core_B, bus.core_label} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_data: got addr=%0h A=%0h B=%0h L=%0h expected all 0",
               bus.mem_addr, bus.core_A, bus.core_B, bus.core_label);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (done_cyc.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_done: got dones=%0d busy=%b expected 0 0",
               done_cyc.size(), busy);
    end
    n_checks++;
    if (a_q.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL reset_reads: got %0d expected 3", a_q.size());
    end
  endtask

  task automatic test_basic();
    int r;
    int n = 4;
    logic [DATA_W-1:0] tp = 32'h0010_0020;
    clear_logs();
    launch(tp, n, r);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != r + n + LIST_LAT + 3) begin
      n_fail++;
      $display("[TB] FAIL basic_done: got n=%0d at %0d expected 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - r : -1, n + LIST_LAT + 3);
    end
    n_checks++;
    if (start_cyc.size() != 1 || start_cyc[0] != r) begin
      n_fail++;
      $display("[TB] FAIL basic_start: got %0d pulses expected 1 at accept", start_cyc.size());
    end
    n_checks++;
    if (v_cyc.size() != n) begin
      n_fail++;
      $display("[TB] FAIL basic_valid_cnt: got %0d expected %0d", v_cyc.size(), n);
    end
    for (int i = 0; i < n && i < v_cyc.size(); i++) begin
      n_checks++;
      if (v_cyc[i] != r + 2 + i || v_b[i] !== mem_d[i] || v_l[i] !== mem_l[i]) begin
        n_fail++;
        $display("[TB] FAIL basic_row%0d: got cyc=+%0d B=%0h L=%0h expected +%0d %0h %0h",
                 i, v_cyc[i] - r, v_b[i], v_l[i], 2 + i, mem_d[i], mem_l[i]);
      end
    end
    n_checks++;
    if (bus.core_A !== tp || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_hold: got A=%0h busy=%b expected %0h 0", bus.core_A, busy, tp);
    end
  endtask

  task automatic test_zero();
    int r;
    clear_logs();
    launch($urandom, 0, r);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != r + LIST_LAT + 3) begin
      n_fail++;
      $display("[TB] FAIL zero_done: got n=%0d at %0d expected 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - r : -1, LIST_LAT + 3);
    end
    n_checks++;
    if (start_cyc.size() != 1 || a_q.size() != 0 || v_cyc.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL zero_traffic: got start=%0d reads=%0d valids=%0d expected 1 0 0",
               start_cyc.size(), a_q.size(), v_cyc.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int r;
      int bad = 0;
      int n = $urandom_range(1, 40);
      logic [DATA_W-1:0] tp = $urandom;
      clear_logs();
      launch(tp, n, r);
      for (int i = 0; i < n + 40; i++) begin
        @(negedge clk);
        if (done) break;
      end
      @(negedge clk);
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != r + n + LIST_LAT + 3) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_done: got n=%0d at %0d expected 1 at %0d", k,
                 done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - r : -1, n + LIST_LAT + 3);
      end
      for (int i = 0; i < v_cyc.size(); i++)
        if (i >= n || v_cyc[i] != r + 2 + i || v_b[i] !== mem_d[i] || v_l[i] !== mem_l[i]) bad++;
      n_checks++;
      if (v_cyc.size() != n || bad != 0) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_stream: got %0d valids %0d bad expected %0d valids 0 bad",
                 k, v_cyc.size(), bad, n);
      end
      n_checks++;
      if (bus.core_A !== tp) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_coreA: got %0h expected %0h", k, bus.core_A, tp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r;
    int n = 3;
    logic [DATA_W-1:0] tp1 = $urandom;
    logic [DATA_W-1:0] tp2 = ~tp1;
    clear_logs();
    @(negedge clk);
    run = 1'b1;
    test_point = tp1;
    n_train = (ADDR_W+1)'(n);
    @(negedge clk);
    r = cyc;
    test_point = tp2;
    repeat (n + LIST_LAT + 4) @(negedge clk);
    n_checks++;
    if (bus.core_A !== tp1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_gap: got A=%0h busy=%b expected %0h 0", bus.core_A, busy, tp1);
    end
    @(negedge clk);
    run = 1'b0;
    n_checks++;
    if (bus.core_A !== tp2 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got A=%0h busy=%b expected %0h 1", bus.core_A, busy, tp2);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);
    n_checks++;
    if (start_cyc.size() != 2 || start_cyc[0] != r || start_cyc[1] != r + n + LIST_LAT + 5) begin
      n_fail++;
      $display("[TB] FAIL b2b_starts: got %0d starts, second at +%0d expected 2, +%0d",
               start_cyc.size(), (start_cyc.size() > 1) ? start_cyc[1] - r : -1, n + LIST_LAT + 5);
    end
    n_checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != r + n + LIST_LAT + 3 ||
        done_cyc[1] != r + 2 * n + 2 * LIST_LAT + 8) begin
      n_fail++;
      $display("[TB] FAIL b2b_dones: got %0d dones expected 2 at +%0d and +%0d",
               done_cyc.size(), n + LIST_LAT + 3, 2 * n + 2 * LIST_LAT + 8);
    end
    n_checks++;
    if (v_cyc.size() != 2 * n) begin
      n_fail++;
      $display("[TB] FAIL b2b_valids: got %0d expected %0d", v_cyc.size(), 2 * n);
    end
  endtask

  task automatic test_full_depth();
    int r;
    int bad_a = 0;
    int bad_v = 0;
    clear_logs();
    launch($urandom, DEPTH, r);
    for (int i = 0; i < DEPTH + 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != r + DEPTH + LIST_LAT + 3) begin
      n_fail++;
      $display("[TB] FAIL full_done: got n=%0d at %0d expected 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - r : -1, DEPTH + LIST_LAT + 3);
    end
    for (int i = 0; i < a_q.size(); i++)
      if (a_q[i] != i) bad_a++;
    n_checks++;
    if (a_q.size() != DEPTH || bad_a != 0) begin
      n_fail++;
      $display("[TB] FAIL full_addr: got %0d reads %0d out of order expected %0d 0",
               a_q.size(), bad_a, DEPTH);
    end
    for (int i = 0; i < v_cyc.size(); i++)
      if (i >= DEPTH || v_cyc[i] != r + 2 + i || v_b[i] !== mem_d[i] || v_l[i] !== mem_l[i]) bad_v++;
    n_checks++;
    if (v_cyc.size() != DEPTH || bad_v != 0) begin
      n_fail++;
      $display("[TB] FAIL full_stream: got %0d valids %0d bad expected %0d 0",
               v_cyc.size(), bad_v, DEPTH);
    end
  endtask

`ifdef KNN_SCHED_PAUSE_EN
  task automatic test_pause();
    int r;
    int n = 6;
    int paused = 3;
    int bad = 0;
    clear_logs();
    launch($urandom, n, r);
    repeat (3) @(posedge clk);
    #1 pause = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_addr !== ADDR_W'(2)) begin
      n_fail++;
      $display("[TB] FAIL pause_hold: got en=%b addr=%0d expected 0 2", bus.mem_en, bus.mem_addr);
    end
    repeat (paused) @(posedge clk);
    #1 pause = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != r + n + LIST_LAT + 3 + paused) begin
      n_fail++;
      $display("[TB] FAIL pause_done: got n=%0d at %0d expected 1 at %0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - r : -1, n + LIST_LAT + 3 + paused);
    end
    for (int i = 0; i < v_cyc.size(); i++)
      if (i >= n || v_b[i] !== mem_d[i] || v_l[i] !== mem_l[i]) bad++;
    for (int i = 0; i < a_q.size(); i++)
      if (a_q[i] != i) bad++;
    n_checks++;
    if (v_cyc.size() != n || a_q.size() != n || bad != 0) begin
      n_fail++;
      $display("[TB] FAIL pause_stream: got %0d valids %0d reads %0d bad expected %0d %0d 0",
               v_cyc.size(), a_q.size(), bad, n, n);
    end
  endtask
`endif

  initial begin
    bus.mem_data  = '0;
    bus.mem_label = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = $urandom;
      mem_l[i] = LABEL'($urandom);
    end
    test_reset();
    test_basic();
    test_zero();
    test_random();
    test_back_to_back();
    test_full_depth();
`ifdef KNN_SCHED_PAUSE_EN
    test_pause();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
